// File: rtl/serial_parallel_rx_n.sv
// serial_parallel_rx_n: multi-lane serial-to-parallel receiver.
// Each lane independently hunts for the COM symbol and locks after LOCK_COUNT
// aligned commas. Once locked it delivers data words with a valid strobe,
// suppressing COM and IDLE words. Misaligned commas seen while locked are
// counted. Reaching LOCK_COUNT of them forces a realign onto the offending
// comma and raises a one-cycle lock_err pulse.
module serial_parallel_rx_n #(
    parameter int               WIDTH      = 8,
    parameter int               LANES      = 4,
    parameter logic [WIDTH-1:0] COM        = 8'hBC,
    parameter logic [WIDTH-1:0] IDLE       = 8'h7C,
    parameter int               LOCK_COUNT = 4,
    parameter bit               MSB_FIRST  = 1'b1
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic [LANES-1:0]       data_in_serial,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic [LANES-1:0]       lane_active,
    output logic                   active,
    output logic [LANES-1:0]       lock_err
);

    // Bit position within a word.
    localparam int BCW = $clog2(WIDTH);
    // Comma counters must be able to hold LOCK_COUNT itself.
    localparam int CCW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            state_t           state_reg;
            logic [WIDTH-1:0] sr_reg;
            logic [WIDTH-1:0] sr_next;
            logic [WIDTH-1:0] word_reg;
            logic [BCW-1:0]   bit_cnt_reg;
            logic [BCW-1:0]   bit_cnt_next;
            logic [CCW-1:0]   com_cnt_reg;
            logic [CCW-1:0]   mis_cnt_reg;
            logic             valid_reg;
            logic             err_reg;
            logic             boundary;
            logic             is_com;
            logic             is_idle;
            logic             com_limit;
            logic             mis_limit;

            // Shift in the current serial bit; all matching uses this value.
            if (MSB_FIRST) begin : g_msb
                assign sr_next = {sr_reg[WIDTH-2:0], data_in_serial[gi]};
            end else begin : g_lsb
                assign sr_next = {data_in_serial[gi], sr_reg[WIDTH-1:1]};
            end

            // Word boundary is the last bit slot of an aligned word.
            assign boundary     = (bit_cnt_reg == BCW'(WIDTH - 1));
            assign bit_cnt_next = boundary ? '0 : bit_cnt_reg + 1'b1;
            assign is_com       = (sr_next == COM);
            assign is_idle      = (sr_next == IDLE);
            // Compare before increment so the counter never has to exceed LOCK_COUNT.
            assign com_limit    = (com_cnt_reg >= CCW'(LOCK_COUNT - 1));
            assign mis_limit    = (mis_cnt_reg >= CCW'(LOCK_COUNT - 1));

            // Per-lane alignment FSM with registered data, valid and error outputs.
            always_ff @(posedge clk_32f or negedge reset) begin
                if (!reset) begin
                    state_reg   <= HUNT;
                    sr_reg      <= '0;
                    word_reg    <= '0;
                    bit_cnt_reg <= '0;
                    com_cnt_reg <= '0;
                    mis_cnt_reg <= '0;
                    valid_reg   <= 1'b0;
                    err_reg     <= 1'b0;
                end else begin
                    sr_reg  <= sr_next;
                    err_reg <= 1'b0;
                    case (state_reg)
                        HUNT: begin
                            bit_cnt_reg <= '0;
                            valid_reg   <= 1'b0;
                            if (is_com) begin
                                com_cnt_reg <= CCW'(1);
                                if (LOCK_COUNT == 1) begin
                                    state_reg   <= ACTIVE;
                                    mis_cnt_reg <= '0;
                                end else begin
                                    state_reg <= LOCKING;
                                end
                            end
                        end

                        LOCKING: begin
                            bit_cnt_reg <= bit_cnt_next;
                            valid_reg   <= 1'b0;
                            if (boundary) begin
                                if (is_com) begin
                                    if (com_limit) begin
                                        state_reg   <= ACTIVE;
                                        mis_cnt_reg <= '0;
                                    end else begin
                                        com_cnt_reg <= com_cnt_reg + 1'b1;
                                    end
                                end else begin
                                    state_reg   <= HUNT;
                                    com_cnt_reg <= '0;
                                end
                            end else if (is_com) begin
                                // A comma off the expected grid restarts the lock on it.
                                com_cnt_reg <= CCW'(1);
                                bit_cnt_reg <= '0;
                            end
                        end

                        ACTIVE: begin
                            bit_cnt_reg <= bit_cnt_next;
                            if (boundary) begin
                                if (is_com) begin
                                    valid_reg   <= 1'b0;
                                    mis_cnt_reg <= '0;
                                end else if (is_idle) begin
                                    valid_reg <= 1'b0;
                                end else begin
                                    word_reg  <= sr_next;
                                    valid_reg <= 1'b1;
                                end
                            end else if (is_com) begin
                                if (mis_limit) begin
                                    // Too many misaligned commas: realign onto this one.
                                    state_reg   <= LOCKING;
                                    com_cnt_reg <= CCW'(1);
                                    mis_cnt_reg <= '0;
                                    bit_cnt_reg <= '0;
                                    valid_reg   <= 1'b0;
                                    err_reg     <= 1'b1;
                                end else begin
                                    mis_cnt_reg <= mis_cnt_reg + 1'b1;
                                end
                            end
                        end

                        default: begin
                            state_reg   <= HUNT;
                            bit_cnt_reg <= '0;
                            com_cnt_reg <= '0;
                            mis_cnt_reg <= '0;
                            valid_reg   <= 1'b0;
                        end
                    endcase
                end
            end

            assign data_out[gi*WIDTH +: WIDTH] = word_reg;
            assign valid_out[gi]               = valid_reg;
            assign lock_err[gi]                = err_reg;
            assign lane_active[gi]             = (state_reg == ACTIVE);
        end
    endgenerate

    // Link is up only when every lane is locked; no extra latency.
    assign active = &lane_active;

endmodule

// File: tb/tb_serial_parallel_rx_n.sv
// Testbench for serial_parallel_rx_n: directed serial streams with a per-lane
// scoreboard of expected data words checked by an independent monitor.
// dut_a is MSB-first (default parameters), dut_b is LSB-first.
module tb_serial_parallel_rx_n;

    localparam int W = 8;

    logic        clk_32f = 1'b0;
    logic        rst_n   = 1'b0;
    logic [3:0]  sin_a   = '0;
    logic [3:0]  sin_b   = '0;
    logic [31:0] dout_a, dout_b;
    logic [3:0]  valid_a, valid_b, lact_a, lact_b, lerr_a, lerr_b;
    logic        act_a, act_b;

    int tests = 0;
    int fails = 0;

    // Expected words: indices 0..3 are dut_a lanes, 4..7 are dut_b lanes.
    logic [7:0] exp_q [8][$];

    always #5 clk_32f = ~clk_32f;

    serial_parallel_rx_n #(.MSB_FIRST(1'b1)) dut_a (
        .clk_32f        (clk_32f),
        .reset          (rst_n),
        .data_in_serial (sin_a),
        .data_out       (dout_a),
        .valid_out      (valid_a),
        .lane_active    (lact_a),
        .active         (act_a),
        .lock_err       (lerr_a)
    );

    serial_parallel_rx_n #(.MSB_FIRST(1'b0)) dut_b (
        .clk_32f        (clk_32f),
        .reset          (rst_n),
        .data_in_serial (sin_b),
        .data_out       (dout_b),
        .valid_out      (valid_b),
        .lane_active    (lact_b),
        .active         (act_b),
        .lock_err       (lerr_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One serial bit per lane; returns just after the sampling edge.
    task automatic step(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk_32f);
        sin_a = a;
        sin_b = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Send a word MSB first on dut_a lane 0.
    task automatic send_a(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) step({3'b000, w[i]}, 4'b0000);
    endtask

    // Monitor: a new word is reported when valid rises or after WIDTH held cycles.
    initial begin
        logic [7:0] prev_valid;
        int         run [8];
        logic [7:0] last_exp [8];
        logic       v, la;
        logic [7:0] d, e;
        prev_valid = '0;
        for (int i = 0; i < 8; i++) begin
            run[i]      = 0;
            last_exp[i] = '0;
        end
        forever begin
            @(negedge clk_32f);
            for (int i = 0; i < 8; i++) begin
                if (i < 4) begin
                    v  = valid_a[i];
                    la = lact_a[i];
                    d  = dout_a[i*8 +: 8];
                end else begin
                    v  = valid_b[i-4];
                    la = lact_b[i-4];
                    d  = dout_b[(i-4)*8 +: 8];
                end
                if (v) check($sformatf("valid_needs_active_lane%0d", i), {31'd0, la}, 32'd1);
                if (v && (!prev_valid[i] || run[i] == W)) begin
                    if (exp_q[i].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word lane%0d: got %02h, expected no word", i, d);
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("word_lane%0d", i), {24'd0, d}, {24'd0, e});
                        $display("[TB] lane%0d word %02h (expected %02h)", i, d, e);
                        last_exp[i] = e;
                    end
                    run[i] = 1;
                end else if (v) begin
                    check($sformatf("data_hold_lane%0d", i), {24'd0, d}, {24'd0, last_exp[i]});
                    run[i]++;
                end
                prev_valid[i] = v;
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] bc;
        logic [7:0] w;
        int         errs;
        int         off [4];
        logic       bq [4][$];
        logic [3:0] bv;

        bc = 8'hBC;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk_32f);
        #1;
        check("reset_data_out", dout_a, 32'd0);
        check("reset_valid", {28'd0, valid_a}, 32'd0);
        check("reset_lane_active", {28'd0, lact_a}, 32'd0);
        check("reset_lock_err", {28'd0, lerr_a}, 32'd0);
        @(negedge clk_32f);
        rst_n = 1'b1;

        // ---------------- lock and data ----------------
        repeat (3) send_a(bc);
        check("active_before_4th_com", {31'd0, lact_a[0]}, 32'd0);
        for (int i = 7; i >= 0; i--) begin
            step({3'b000, bc[i]}, 4'b0000);
            if (i == 1) check("lane_active_bit31", {31'd0, lact_a[0]}, 32'd0);
        end
        check("lane_active_bit32", {31'd0, lact_a[0]}, 32'd1);
        check("lock_com_not_valid", {31'd0, valid_a[0]}, 32'd0);

        exp_q[0].push_back(8'h05);
        send_a(8'h05);
        check("data05_valid", {31'd0, valid_a[0]}, 32'd1);

        // ---------------- idle suppression ----------------
        send_a(8'h7C);
        check("idle_valid", {31'd0, valid_a[0]}, 32'd0);
        check("idle_data_held", {24'd0, dout_a[7:0]}, 32'h05);
        exp_q[0].push_back(8'hA3);
        send_a(8'hA3);
        check("dataA3_valid", {31'd0, valid_a[0]}, 32'd1);

        // ---------------- asynchronous reset mid-word ----------------
        repeat (3) step(4'b0000, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_data", dout_a, 32'd0);
        check("async_reset_valid", {28'd0, valid_a}, 32'd0);
        check("async_reset_lane_active", {28'd0, lact_a}, 32'd0);
        check("async_reset_active", {31'd0, act_a}, 32'd0);
        check("async_reset_lock_err", {28'd0, lerr_a}, 32'd0);
        @(negedge clk_32f);
        rst_n = 1'b1;

        // ---------------- failed lock, then relock ----------------
        repeat (3) begin
            send_a(bc);
            check("failed_lock_no_active", {31'd0, lact_a[0]}, 32'd0);
        end
        send_a(8'h00);
        check("failed_lock_back_to_hunt", {31'd0, lact_a[0]}, 32'd0);
        repeat (3) send_a(bc);
        check("relock_not_yet", {31'd0, lact_a[0]}, 32'd0);
        send_a(bc);
        check("relock_active", {31'd0, lact_a[0]}, 32'd1);

        // ---------------- slip ----------------
        exp_q[0].push_back(8'h66);
        send_a(8'h66);
        // Words seen on the shifted grid before the realign.
        exp_q[0].push_back(8'h5B);
        exp_q[0].push_back(8'h79);
        exp_q[0].push_back(8'h79);
        exp_q[0].push_back(8'h79);
        w = 8'h5A;
        for (int i = 7; i >= 1; i--) step({3'b000, w[i]}, 4'b0000);
        errs = 0;
        for (int k = 1; k <= 7; k++) begin
            for (int i = 7; i >= 0; i--) begin
                step({3'b000, bc[i]}, 4'b0000);
                if (lerr_a[0]) errs++;
            end
            if (k == 3) check("no_err_before_4th_miscomma", {31'd0, lerr_a[0]}, 32'd0);
            if (k == 4) check("lock_err_on_4th_miscomma", {31'd0, lerr_a[0]}, 32'd1);
            if (k >= 4 && k <= 6) check($sformatf("slip_inactive_word%0d", k), {31'd0, lact_a[0]}, 32'd0);
            if (k == 7) check("slip_relocked", {31'd0, lact_a[0]}, 32'd1);
        end
        check("lock_err_pulse_count", errs, 32'd1);
        exp_q[0].push_back(8'hC3);
        send_a(8'hC3);
        check("post_slip_valid", {31'd0, valid_a[0]}, 32'd1);
        send_a(8'h7C);

        // ---------------- multi-lane, LSB first ----------------
        @(negedge clk_32f);
        rst_n = 1'b0;
        sin_a = '0;
        sin_b = '0;
        @(negedge clk_32f);
        rst_n = 1'b1;
        off[0] = 5;
        off[1] = 9;
        off[2] = 0;
        off[3] = 13;
        for (int i = 0; i < 4; i++) begin
            repeat (off[i]) bq[i].push_back(1'b0);
            for (int k = 0; k < 6; k++) begin
                if (k < 4) w = 8'hBC;
                else w = {4'(i + 1), 4'(k - 3)};
                if (k >= 4) exp_q[4+i].push_back(w);
                for (int b = 0; b < 8; b++) bq[i].push_back(w[b]);
            end
        end
        for (int s = 1; s <= 80; s++) begin
            for (int i = 0; i < 4; i++) begin
                if (bq[i].size() == 0) begin
                    w = 8'h7C;
                    for (int b = 0; b < 8; b++) bq[i].push_back(w[b]);
                end
                bv[i] = bq[i].pop_front();
            end
            step(4'b0000, bv);
            for (int i = 0; i < 4; i++) begin
                if (s == off[i] + 31) check($sformatf("lsb_lane%0d_not_locked", i), {31'd0, lact_b[i]}, 32'd0);
                if (s == off[i] + 32) check($sformatf("lsb_lane%0d_locked", i), {31'd0, lact_b[i]}, 32'd1);
            end
            if (s == 44) check("active_before_last_lane", {31'd0, act_b}, 32'd0);
            if (s == 45) check("active_after_last_lane", {31'd0, act_b}, 32'd1);
        end

        for (int i = 0; i < 8; i++) check($sformatf("queue_empty_%0d", i), exp_q[i].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_parallel_rx_n.md
# serial_parallel_rx_n

Parametrised multi-lane serial-to-parallel receiver that replaces the fixed 4-lane, 8-bit receive path. Each of `LANES` serial lanes finds its own word alignment by hunting for the COM symbol, locks after `LOCK_COUNT` aligned COMs, and then delivers data words with valid strobes, suppressing COM and IDLE. Unlike the previous generation, it also detects loss of alignment: repeated misaligned commas force a realign and raise a per-lane error pulse. It sits between the serial link and the lane un-striping logic, in the `clk_32f` domain.

## Interface
- `WIDTH`, 8, bits per word (≥2)
- `LANES`, 4, number of serial lanes (≥1)
- `COM`, 8'hBC, comma/alignment symbol, `WIDTH` bits
- `IDLE`, 8'h7C, idle symbol, `WIDTH` bits (≠`COM`)
- `LOCK_COUNT`, 4, consecutive aligned COMs to lock; also the misaligned-COM limit (≥1)
- `MSB_FIRST`, 1, 1 = first serial bit is word MSB; 0 = LSB first
- `clk_32f`  in  1  bit clock; the only clock
- `reset`  in  1  asynchronous, active-low reset
- `data_in_serial`  in  LANES  one serial bit per lane per clock
- `data_out`  out  LANES*WIDTH  lane i word at `[i*WIDTH +: WIDTH]`
- `valid_out`  out  LANES  lane i `data_out` holds a data word
- `lane_active`  out  LANES  lane i is in ACTIVE
- `active`  out  1  AND of all `lane_active`
- `lock_err`  out  LANES  one-cycle pulse when lane i drops lock

## Operation
- Lanes are fully independent. `active` is combinational from the `lane_active` registers and adds no latency.
- Per lane: a `WIDTH`-bit shift register `sr`.
  - `MSB_FIRST`=1: `sr_n = {sr[W-2:0], bit}`.
  - `MSB_FIRST`=0: `sr_n = {bit, sr[W-1:1]}`.
  - All comparisons use `sr_n`, the value that includes the current bit.
- `bit_cnt` is `$clog2(WIDTH)` bits wide, counts modulo `WIDTH`, and is 0 on the cycle after an alignment event. A word boundary is the cycle with `bit_cnt`==`WIDTH-1`.
- State HUNT (reset state): `sr_n`==COM → LOCKING, `com_cnt`=1, `bit_cnt`=0.
- State LOCKING:
  - At a boundary, word==COM → `com_cnt`+1; when `com_cnt` reaches `LOCK_COUNT` → ACTIVE, `mis_cnt`=0.
  - At a boundary, word≠COM → HUNT, `com_cnt`=0.
  - Off a boundary, `sr_n`==COM → realign: stay in LOCKING, `com_cnt`=1, `bit_cnt`=0.
  - `LOCK_COUNT`=1 → HUNT goes straight to ACTIVE.
- State ACTIVE, at a boundary:
  - word==COM → `valid_out`=0, `data_out` held, `mis_cnt`=0.
  - word==IDLE → `valid_out`=0, `data_out` held.
  - Any other word → `data_out`=word, `valid_out`=1.
  - `data_out` and `valid_out` are held until the next boundary.
- State ACTIVE, off a boundary, `sr_n`==COM → `mis_cnt`+1. When `mis_cnt` reaches `LOCK_COUNT`:
  - → LOCKING, realigned to this comma (`com_cnt`=1, `bit_cnt`=0).
  - `lock_err`=1 for exactly one cycle, `valid_out`=0.
- `lane_active` = (state==ACTIVE). Any exit from ACTIVE clears `valid_out` at the same edge.

## Timing
- All state, `data_out`, `valid_out` and `lock_err` are registered on rising `clk_32f`.
- Reset (`reset`=0, asynchronous, immediate): every output is 0; `sr`, counters and state clear to 0/HUNT. This holds mid-word and mid-lock. Operation resumes at the first rising edge after release.
- Data latency: the last bit of a word is sampled at edge k; `data_out`/`valid_out` reflect that word after edge k and stay stable for `WIDTH` cycles.
- Lock: `lane_active` rises after the edge that samples the last bit of the `LOCK_COUNT`-th aligned COM. That COM itself yields `valid_out`=0.
- `lock_err` is high for the single cycle after the edge on which the limit is reached.

## Test plan
- Reset: drop `reset` mid-stream while lane 0 is ACTIVE with `valid_out`=1 → all outputs are 0 before the next edge; after release, lane 0 must re-hunt.
- Lock and data (default params, MSB first): lane 0 sends BC,BC,BC,BC,05 →
  - `lane_active[0]`=1 after bit 32.
  - `data_out[7:0]`=05 and `valid_out[0]`=1 after bit 40, held 8 cycles.
- Idle suppression: after 05, send 7C then A3 → `valid_out[0]`=0 for the 7C word with `data_out` still 05; then A3 with `valid_out[0]`=1.
- Failed lock: BC,BC,BC,00 → back to HUNT with `lane_active[0]` never asserted; a following BC×4 locks normally.
- Slip: once ACTIVE, delete one serial bit, then send BC×7 →
  - `lock_err[0]` pulses once on the 4th misaligned comma.
  - `lane_active[0]` low for the 3 words that follow, then high again.
  - No `valid_out` while unlocked.
- Multi-lane and LSB first (`MSB_FIRST`=0, lanes locked 5, 9, 0, 13 bits apart) → `active` rises only after the last lane locks; per-lane data is reported LSB-first-correct in its own slice.
